// File: rtl/acc_sequencer_if.sv
// Control/status bundle between the radar control registers and acc_sequencer.
// The master side drives the run request and configuration; the slave side reports triggers and status.
interface acc_sequencer_if #(
   parameter int PRI_W    = 32,
   parameter int MAX_LOG2 = 8
);
   logic                start;
   logic                abort;
   logic [3:0]          cfg_log2cnt;
   logic [PRI_W-1:0]    cfg_pri;
   logic [15:0]         cfg_ncpi;
   logic                trig;
   logic                trig_int;
   logic [15:0]         shift;
   logic                busy;
   logic [MAX_LOG2-1:0] pulse_idx;
   logic                cpi_done;
   logic                run_done;
   logic                cfg_err;

   modport master (
      output start, abort, cfg_log2cnt, cfg_pri, cfg_ncpi,
      input  trig, trig_int, shift, busy, pulse_idx, cpi_done, run_done, cfg_err
   );

   modport slave (
      input  start, abort, cfg_log2cnt, cfg_pri, cfg_ncpi,
      output trig, trig_int, shift, busy, pulse_idx, cpi_done, run_done, cfg_err
   );
endinterface

// File: rtl/acc_sequencer.sv
// Trigger scheduler for the coherent accumulator: emits 2^N triggers per CPI spaced by PRI,
// for a programmed number of CPIs or continuously until aborted.
module acc_sequencer #(
   parameter int DEPTH    = 4096,
   parameter int MAX_LOG2 = 8,
   parameter int PRI_W    = 32
) (
   input  logic            clk,
   input  logic            rst,
   acc_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [PRI_W-1:0]    PRI_ONE  = PRI_W'(32'd1);
   localparam logic [PRI_W-1:0]    PRI_TWO  = PRI_W'(32'd2);
   localparam logic [PRI_W-1:0]    PRI_MIN  = PRI_W'(DEPTH);
   localparam logic [3:0]          LOG2_MAX = 4'(MAX_LOG2);
   localparam logic [MAX_LOG2-1:0] IDX_ONE  = MAX_LOG2'(32'd1);
   localparam logic [MAX_LOG2:0]   WRAP_ONE = (MAX_LOG2+1)'(32'd1);

   state_t              state_r, state_s;
   logic [PRI_W-1:0]    timer_r, timer_s, pri_r, pri_s;
   logic [3:0]          log2_r, log2_s;
   logic [15:0]         ncpi_r, ncpi_s, cpi_cnt_r, cpi_cnt_s, cpi_next_s;
   logic [MAX_LOG2-1:0] idx_r, idx_s;
   logic [MAX_LOG2:0]   idx_last_s;
   logic                cpi_end_r, cpi_end_s, last_r, last_s;
   logic                trig_r, trig_s, trig_int_r, trig_int_s;
   logic                cpi_done_r, cpi_done_s, run_done_r, run_done_s;
   logic                cfg_err_r, cfg_err_s, busy_r, busy_s;
   logic [15:0]         shift_r, shift_s;
   logic [MAX_LOG2-1:0] pulse_idx_r, pulse_idx_s;

   // Next-state and registered-output computation.
   // idx_r holds the index of the next trigger to fire; cpi_end_r/last_r carry a CPI wrap decided at
   // timer expiry into the following FIRE cycle so that cpi_done/run_done line up with the trigger slot.
   always_comb begin
      state_s     = state_r;
      timer_s     = timer_r;
      pri_s       = pri_r;
      log2_s      = log2_r;
      ncpi_s      = ncpi_r;
      cpi_cnt_s   = cpi_cnt_r;
      idx_s       = idx_r;
      cpi_end_s   = cpi_end_r;
      last_s      = last_r;
      trig_s      = 1'b0;
      trig_int_s  = 1'b0;
      cpi_done_s  = 1'b0;
      run_done_s  = 1'b0;
      cfg_err_s   = 1'b0;
      busy_s      = busy_r;
      shift_s     = shift_r;
      pulse_idx_s = pulse_idx_r;
      cpi_next_s  = cpi_cnt_r + 16'd1;
      idx_last_s  = (WRAP_ONE << log2_r) - WRAP_ONE;

      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               if ((bus.cfg_pri >= PRI_MIN) && (bus.cfg_log2cnt <= LOG2_MAX)) begin
                  pri_s     = bus.cfg_pri;
                  log2_s    = bus.cfg_log2cnt;
                  ncpi_s    = bus.cfg_ncpi;
                  shift_s   = {12'd0, bus.cfg_log2cnt};
                  cpi_cnt_s = 16'd0;
                  idx_s     = '0;
                  cpi_end_s = 1'b0;
                  last_s    = 1'b0;
                  busy_s    = 1'b1;
                  state_s   = ST_FIRE;
               end else begin
                  cfg_err_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FIRE: begin
            if (bus.abort) begin
               run_done_s = 1'b1;
               busy_s     = 1'b0;
               state_s    = ST_IDLE;
            end else if (last_r) begin
               cpi_done_s = 1'b1;
               run_done_s = 1'b1;
               busy_s     = 1'b0;
               state_s    = ST_IDLE;
            end else begin
               trig_s      = 1'b1;
               trig_int_s  = (idx_r == '0);
               cpi_done_s  = cpi_end_r;
               pulse_idx_s = idx_r;
               cpi_end_s   = 1'b0;
               timer_s     = pri_r - PRI_TWO;
               state_s     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.abort) begin
               run_done_s = 1'b1;
               busy_s     = 1'b0;
               state_s    = ST_IDLE;
            end else if (timer_r != '0) begin
               timer_s = timer_r - PRI_ONE;
            end else begin
               state_s = ST_FIRE;
               if ({1'b0, idx_r} == idx_last_s) begin
                  idx_s     = '0;
                  cpi_end_s = 1'b1;
                  cpi_cnt_s = cpi_next_s;
                  // Continuous mode (ncpi == 0) never terminates on the CPI count.
                  last_s    = (ncpi_r != 16'd0) && (cpi_next_s == ncpi_r);
               end else begin
                  idx_s = idx_r + IDX_ONE;
               end
            end
         end
         default: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         timer_r     <= '0;
         pri_r       <= '0;
         log2_r      <= 4'd0;
         ncpi_r      <= 16'd0;
         cpi_cnt_r   <= 16'd0;
         idx_r       <= '0;
         cpi_end_r   <= 1'b0;
         last_r      <= 1'b0;
         trig_r      <= 1'b0;
         trig_int_r  <= 1'b0;
         cpi_done_r  <= 1'b0;
         run_done_r  <= 1'b0;
         cfg_err_r   <= 1'b0;
         busy_r      <= 1'b0;
         shift_r     <= 16'd0;
         pulse_idx_r <= '0;
      end else begin
         state_r     <= state_s;
         timer_r     <= timer_s;
         pri_r       <= pri_s;
         log2_r      <= log2_s;
         ncpi_r      <= ncpi_s;
         cpi_cnt_r   <= cpi_cnt_s;
         idx_r       <= idx_s;
         cpi_end_r   <= cpi_end_s;
         last_r      <= last_s;
         trig_r      <= trig_s;
         trig_int_r  <= trig_int_s;
         cpi_done_r  <= cpi_done_s;
         run_done_r  <= run_done_s;
         cfg_err_r   <= cfg_err_s;
         busy_r      <= busy_s;
         shift_r     <= shift_s;
         pulse_idx_r <= pulse_idx_s;
      end
   end

   assign bus.trig      = trig_r;
   assign bus.trig_int  = trig_int_r;
   assign bus.cpi_done  = cpi_done_r;
   assign bus.run_done  = run_done_r;
   assign bus.cfg_err   = cfg_err_r;
   assign bus.busy      = busy_r;
   assign bus.shift     = shift_r;
   assign bus.pulse_idx = pulse_idx_r;
endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: directed runs with randomized configuration noise,
// compared every cycle against a timeline model built from trigger arithmetic.
module tb_acc_sequencer;
   localparam int DEPTH    = 4096;
   localparam int MAX_LOG2 = 8;
   localparam int PRI_W    = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   // Current run description used by the timeline model (m_abort < 0: no abort).
   int m_lg, m_pri, m_ncpi, m_abort;

   acc_sequencer_if #(.PRI_W(PRI_W), .MAX_LOG2(MAX_LOG2)) bus ();

   acc_sequencer #(.DEPTH(DEPTH), .MAX_LOG2(MAX_LOG2), .PRI_W(PRI_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_vec();
      return {26'd0, bus.trig, bus.trig_int, bus.cpi_done, bus.run_done, bus.busy, bus.cfg_err};
   endfunction

   // Expected {trig,trig_int,cpi_done,run_done,busy,cfg_err} d cycles after the start cycle.
   function automatic logic [31:0] exp_vec(input int d);
      int  n, end_d, k;
      bit  aborted, grid, t, ti, cd;
      n       = 1 << m_lg;
      aborted = (m_abort >= 0);
      if (aborted)          end_d = m_abort + 1;
      else if (m_ncpi == 0) end_d = 32'h7fff_ffff;
      else                  end_d = 2 + n * m_ncpi * m_pri;
      grid = (d >= 2) && (((d - 2) % m_pri) == 0);
      k    = (d - 2) / m_pri;
      t    = grid && (d < end_d);
      ti   = t && ((k % n) == 0);
      cd   = grid && (k > 0) && ((k % n) == 0) && ((d < end_d) || ((d == end_d) && !aborted));
      return {26'd0, t, ti, cd, (d == end_d), (d >= 1) && (d < end_d), 1'b0};
   endfunction

   // Issue a start, then check every cycle up to the end of the run (or stop_d if positive).
   task automatic run(input int lg, input int pri, input int ncpi, input int abort_d,
                      input int mid_d, input bit abort_with_start, input int stop_d);
      int          last_d;
      logic [31:0] e;
      m_lg = lg; m_pri = pri; m_ncpi = ncpi; m_abort = abort_d;
      last_d = (abort_d >= 0) ? abort_d + 4 : 2 + (1 << lg) * ncpi * pri + 3;
      if (stop_d > 0) last_d = stop_d;
      bus.cfg_log2cnt = 4'(lg);
      bus.cfg_pri     = 32'(pri);
      bus.cfg_ncpi    = 16'(ncpi);
      bus.start       = 1'b1;
      bus.abort       = abort_with_start;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      for (int d = 1; d <= last_d; d++) begin
         e = exp_vec(d);
         chk("ctrl", obs_vec(), e);
         if (e[5]) begin
            chk("pulse_idx", 32'(bus.pulse_idx), 32'(((d - 2) / pri) % (1 << lg)));
            chk("shift", 32'(bus.shift), 32'(lg));
         end
         bus.cfg_pri     = $urandom;
         bus.cfg_log2cnt = 4'($urandom_range(0, 15));
         bus.cfg_ncpi    = 16'($urandom);
         bus.start       = (d == mid_d);
         bus.abort       = (d == abort_d);
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic reject(input int lg, input int pri);
      bus.cfg_log2cnt = 4'(lg);
      bus.cfg_pri     = 32'(pri);
      bus.cfg_ncpi    = 16'd1;
      bus.start       = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int d = 1; d <= 6; d++) begin
         chk("cfg_err", obs_vec(), (d == 1) ? 32'h1 : 32'h0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.cfg_log2cnt = 4'd0;
      bus.cfg_pri     = 32'd0;
      bus.cfg_ncpi    = 16'd0;

      #12;
      chk("reset_ctrl", obs_vec(), 32'h0);
      chk("reset_shift", 32'(bus.shift), 32'h0);
      chk("reset_pulse_idx", 32'(bus.pulse_idx), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.abort = 1'b1;  // abort in IDLE is ignored
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("idle_abort", obs_vec(), 32'h0);

      // 4 pulses, one CPI, with an ignored mid-run start carrying a different config.
      run(2, 5000, 1, -1, 7000, 1'b0, 0);

      // Rejected configurations, then boundary-legal ones.
      reject(2, DEPTH - 1);
      reject(MAX_LOG2 + 1, 5000);
      run(MAX_LOG2, DEPTH, 1, 3, -1, 1'b0, 0);

      // Multi-CPI run at minimum PRI.
      run(1, DEPTH, 3, -1, -1, 1'b0, 0);

      // Random short run.
      run($urandom_range(0, 1), $urandom_range(DEPTH, DEPTH + 104), $urandom_range(1, 2), -1, -1, 1'b0, 0);

      // Continuous mode, aborted in the FIRE cycle of the fifth trigger.
      run(0, DEPTH, 0, 1 + 4 * DEPTH, -1, 1'b0, 0);

      // Reset asserted mid-WAIT.
      run(2, DEPTH, 1, -1, -1, 1'b0, 1500);
      rst = 1'b1;
      #2;
      chk("rst_async_ctrl", obs_vec(), 32'h0);
      chk("rst_async_shift", 32'(bus.shift), 32'h0);
      chk("rst_async_pulse_idx", 32'(bus.pulse_idx), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_hold_ctrl", obs_vec(), 32'h0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", obs_vec(), 32'h0);

      // Start and abort together in IDLE: start wins.
      run(0, DEPTH, 1, -1, -1, 1'b1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Trigger scheduler for the coherent accumulator. Generates the `trig`, `trig_int` and `shift` controls that drive the accumulator on one clock. Each coherent processing interval (CPI) consists of 2^N pulses spaced by a programmable pulse repetition interval (PRI). A run is a programmable number of CPIs, or continuous operation until aborted. The block sits between the radar control registers and the accumulator instances.

## Interface
- `DEPTH`, 4096: accumulator record length in samples; minimum legal PRI.
- `MAX_LOG2`, 8: largest legal log2 of pulses per CPI.
- `PRI_W`, 32: width of PRI counter/config.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a run; honoured only in IDLE.
- `abort` in 1: terminate run; no further triggers.
- `cfg_log2cnt` in 4: log2 of pulses per CPI; sampled on accepted `start`.
- `cfg_pri` in PRI_W: clocks between consecutive triggers; sampled on `start`.
- `cfg_ncpi` in 16: number of CPIs in the run; 0 = continuous; sampled on `start`.
- `trig` out 1: single-cycle accumulator trigger.
- `trig_int` out 1: asserted with `trig` on the first pulse of each CPI (clears integration).
- `shift` out 16: zero-extended latched `cfg_log2cnt`; stable while `busy`.
- `busy` out 1: run in progress.
- `pulse_idx` out MAX_LOG2: index of the most recent trigger within the current CPI.
- `cpi_done` out 1: single-cycle pulse when a CPI's final PRI interval expires.
- `run_done` out 1: single-cycle pulse when a run finishes or is aborted.
- `cfg_err` out 1: single-cycle pulse when a `start` is rejected.

## Operation
- States: IDLE, FIRE, WAIT.
- IDLE:
  - `start`=1 with `cfg_pri`>=DEPTH and `cfg_log2cnt`<=MAX_LOG2: latch the config, set `busy`, go to FIRE.
  - Otherwise, `start`=1 pulses `cfg_err` for one cycle and the block stays in IDLE.
- FIRE (one cycle):
  - Assert `trig`. Assert `trig_int` when `pulse_idx`==0.
  - Load the PRI timer with `cfg_pri`-2 and go to WAIT.
- WAIT:
  - Timer decrements each cycle. At 0, advance the pulse index.
  - If the index wraps at 2^N:
    - Pulse `cpi_done` and increment the CPI counter.
    - If `cfg_ncpi`!=0 and CPI count == `cfg_ncpi`: pulse `run_done`, clear `busy`, go to IDLE.
    - Otherwise go to FIRE.
  - If the index does not wrap, go to FIRE.
- Resulting spacing: consecutive `trig` rising edges are exactly `cfg_pri` cycles apart.
- `cfg_log2cnt`=0 means one pulse per CPI: every trigger carries `trig_int`.
- `abort` in any non-IDLE state:
  - Next state is IDLE and `busy` clears.
  - `run_done` pulses. `cpi_done` does not pulse.
  - If `abort` coincides with a FIRE cycle, abort wins and `trig` stays low.
  - `abort` in IDLE is ignored.
- `start` while busy is ignored: no `cfg_err`, config unchanged.
- `start` and `abort` together in IDLE: start is accepted.
- Config inputs may change freely while busy; only the latched copies are used.
- Counters wrap-safe: the CPI counter is 16 bits, and continuous mode never compares it.
- Asserting `rst` mid-run immediately forces IDLE, and all outputs take their reset values. No `run_done` pulse is generated.

## Timing
- Reset values: `trig`=0, `trig_int`=0, `shift`=0, `busy`=0, `pulse_idx`=0, `cpi_done`=0, `run_done`=0, `cfg_err`=0.
- `start` sampled at edge E:
  - `busy`=1 and `shift` valid after E.
  - First `trig`/`trig_int` are high for the cycle following edge E+1, i.e. one cycle of latency.
- `cfg_err` is high for the cycle after the rejecting edge.
- `cpi_done` and the next CPI's `trig`/`trig_int` are asserted in the same cycle. The last CPI's `cpi_done` coincides with `run_done`.
- `pulse_idx` updates together with `trig`.
- All outputs are registered. No combinational paths exist from inputs to outputs.

## Test plan
- DEPTH=4096, log2cnt=2, pri=5000, ncpi=1:
  - Exactly 4 `trig` pulses, at start+2, +5002, +10002, +15002.
  - `trig_int` only on the first; `shift`=2.
  - `cpi_done` and `run_done` at start+20002.
- log2cnt=2, pri=4096, ncpi=3:
  - 12 triggers spaced 4096 apart, with `trig_int` on triggers 0, 4 and 8.
  - Three `cpi_done` pulses, one `run_done`, then `busy`=0.
- pri=4095 or log2cnt=9:
  - `cfg_err` is a one-cycle pulse.
  - `busy` stays 0 and no `trig` occurs.
- ncpi=0, log2cnt=0, pri=4096:
  - `trig` and `trig_int` on every pulse for 20 pulses.
  - Assert `abort` on the cycle a trigger is due: that trigger is suppressed, `run_done` pulses and `busy` drops.
- Mid-run `start` with different config:
  - Ignored; trigger spacing and `shift` are unchanged.
- `rst` asserted mid-WAIT:
  - Asynchronous return to reset values, with no `run_done`.
  - A subsequent `start` produces its first `trig` at start+2.
